// File: rtl/bottleneck_widener.sv
// rtl/bottleneck_widener.sv - narrow 8/16-bit bus to 64-bit byte-laned bus bridge
// Optional one-line read buffer enabled by defining BOTTLENECK_WIDENER_LINEBUF_EN.
module bottleneck_widener #(
   parameter int ADR_W = 64
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic [ADR_W-1:0] u_adr_i,
   input  logic             u_cyc_i,
   input  logic             u_stb_i,
   input  logic             u_we_i,
   input  logic             u_siz_i,
   input  logic             u_signed_i,
   input  logic [15:0]      u_dat_i,
   output logic             u_ack_o,
   output logic [15:0]      u_dat_o,
   input  logic             flush_i,
   output logic [ADR_W-1:0] d_adr_o,
   output logic             d_cyc_o,
   output logic             d_stb_o,
   output logic             d_we_o,
   output logic [7:0]       d_sel_o,
   output logic [63:0]      d_dat_o,
   input  logic             d_ack_i,
   input  logic [63:0]      d_dat_i
);

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   state_t           state_q, state_d;
   logic [ADR_W-1:0] d_adr_q, d_adr_d;
   logic             d_cyc_q, d_cyc_d;
   logic             d_we_q, d_we_d;
   logic [7:0]       d_sel_q, d_sel_d;
   logic [63:0]      d_dat_q, d_dat_d;
   logic [2:0]       lane_q, lane_d;
   logic             siz_q, siz_d;
   logic             sgn_q, sgn_d;
   logic             abort_q, abort_d;
   logic [15:0]      u_dat_q, u_dat_d;
   logic             req;
   logic             hit;
   logic [63:0]      line_rd;

   function automatic logic [15:0] extract(input logic [63:0] data, input logic [2:0] lane,
                                           input logic siz, input logic sgn);
      logic [63:0] sh;
      logic [7:0]  b;
      if (siz) begin
         sh = data >> {lane[2:1], 4'b0000};
         return sh[15:0];
      end
      sh = data >> {lane, 3'b000};
      b  = sh[7:0];
      return {(sgn ? {8{b[7]}} : 8'h00), b};
   endfunction

   assign req = u_cyc_i & u_stb_i;

   always_comb begin
      state_d = state_q;
      d_adr_d = d_adr_q;
      d_cyc_d = d_cyc_q;
      d_we_d  = d_we_q;
      d_sel_d = d_sel_q;
      d_dat_d = d_dat_q;
      lane_d  = lane_q;
      siz_d   = siz_q;
      sgn_d   = sgn_q;
      abort_d = abort_q;
      u_dat_d = u_dat_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               lane_d  = u_adr_i[2:0];
               siz_d   = u_siz_i;
               sgn_d   = u_signed_i;
               abort_d = 1'b0;
               if (u_we_i) begin
                  state_d = WR;
                  d_cyc_d = 1'b1;
                  d_we_d  = 1'b1;
                  d_adr_d = {u_adr_i[ADR_W-1:3], 3'b000};
                  d_sel_d = u_siz_i ? (8'h03 << {u_adr_i[2:1], 1'b0}) : (8'h01 << u_adr_i[2:0]);
                  d_dat_d = u_siz_i ? {4{u_dat_i}} : {8{u_dat_i[7:0]}};
               end else if (hit) begin
                  state_d = RESP;
                  u_dat_d = extract(line_rd, u_adr_i[2:0], u_siz_i, u_signed_i);
               end else begin
                  state_d = RD;
                  d_cyc_d = 1'b1;
                  d_we_d  = 1'b0;
                  d_adr_d = {u_adr_i[ADR_W-1:3], 3'b000};
                  d_sel_d = 8'hFF;
                  d_dat_d = 64'd0;
               end
            end
         end
         RD, WR: begin
            if (!u_cyc_i) abort_d = 1'b1;
            if (d_ack_i) begin
               // Drop every downstream output so IDLE always presents an all-zero bus.
               d_cyc_d = 1'b0;
               d_we_d  = 1'b0;
               d_sel_d = 8'h00;
               d_adr_d = '0;
               d_dat_d = 64'd0;
               u_dat_d = (state_q == RD) ? extract(d_dat_i, lane_q, siz_q, sgn_q) : 16'h0000;
               state_d = (abort_q || !u_cyc_i) ? IDLE : RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= IDLE;
         d_adr_q <= '0;
         d_cyc_q <= 1'b0;
         d_we_q  <= 1'b0;
         d_sel_q <= 8'h00;
         d_dat_q <= 64'd0;
         lane_q  <= 3'd0;
         siz_q   <= 1'b0;
         sgn_q   <= 1'b0;
         abort_q <= 1'b0;
         u_dat_q <= 16'h0000;
      end else begin
         state_q <= state_d;
         d_adr_q <= d_adr_d;
         d_cyc_q <= d_cyc_d;
         d_we_q  <= d_we_d;
         d_sel_q <= d_sel_d;
         d_dat_q <= d_dat_d;
         lane_q  <= lane_d;
         siz_q   <= siz_d;
         sgn_q   <= sgn_d;
         abort_q <= abort_d;
         u_dat_q <= u_dat_d;
      end
   end

`ifdef BOTTLENECK_WIDENER_LINEBUF_EN
   logic [63:0]      line_q, line_d;
   logic [ADR_W-4:0] tag_q, tag_d;
   logic             valid_q, valid_d;

   assign line_rd = line_q;
   assign hit     = valid_q && (tag_q == u_adr_i[ADR_W-1:3]);

   always_comb begin
      line_d  = line_q;
      tag_d   = tag_q;
      valid_d = valid_q;
      if (flush_i) valid_d = 1'b0;
      if (state_q == WR && d_ack_i && valid_q && tag_q == d_adr_q[ADR_W-1:3]) begin
         for (int n = 0; n < 8; n++) begin
            if (d_sel_q[n]) line_d[8*n +: 8] = d_dat_q[8*n +: 8];
         end
      end
      // A fill sets valid even when a flush lands on the same edge.
      if (state_q == RD && d_ack_i) begin
         line_d  = d_dat_i;
         tag_d   = d_adr_q[ADR_W-1:3];
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         line_q  <= 64'd0;
         tag_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         line_q  <= line_d;
         tag_q   <= tag_d;
         valid_q <= valid_d;
      end
   end
`else
   logic unused_flush;
   assign unused_flush = flush_i;
   assign line_rd      = 64'd0;
   assign hit          = 1'b0;
`endif

   assign u_ack_o = (state_q == RESP);
   assign u_dat_o = u_dat_q;
   assign d_adr_o = d_adr_q;
   assign d_cyc_o = d_cyc_q;
   assign d_stb_o = d_cyc_q;
   assign d_we_o  = d_we_q;
   assign d_sel_o = d_sel_q;
   assign d_dat_o = d_dat_q;

endmodule

// File: tb/tb_bottleneck_widener.sv
// tb/tb_bottleneck_widener.sv - scoreboard bench for bottleneck_widener
module tb_bottleneck_widener;

   localparam int ADR_W = 64;
`ifdef BOTTLENECK_WIDENER_LINEBUF_EN
   localparam bit LB = 1'b1;
`else
   localparam bit LB = 1'b0;
`endif
   localparam logic [63:0] D0 = 64'h1122334455667788;
   localparam logic [63:0] D1 = 64'h11223344AB667788;

   logic             clk_i = 1'b0;
   logic             reset_ni;
   logic [ADR_W-1:0] u_adr_i;
   logic             u_cyc_i, u_stb_i, u_we_i, u_siz_i, u_signed_i;
   logic [15:0]      u_dat_i;
   logic             u_ack_o;
   logic [15:0]      u_dat_o;
   logic             flush_i;
   logic [ADR_W-1:0] d_adr_o;
   logic             d_cyc_o, d_stb_o, d_we_o;
   logic [7:0]       d_sel_o;
   logic [63:0]      d_dat_o;
   logic             d_ack_i;
   logic [63:0]      d_dat_i;

   int vectors = 0;
   int miscompares = 0;
   logic [16:0] exp_q[$];

   bottleneck_widener #(.ADR_W(ADR_W)) dut (
      .clk_i(clk_i), .reset_ni(reset_ni),
      .u_adr_i(u_adr_i), .u_cyc_i(u_cyc_i), .u_stb_i(u_stb_i), .u_we_i(u_we_i),
      .u_siz_i(u_siz_i), .u_signed_i(u_signed_i), .u_dat_i(u_dat_i),
      .u_ack_o(u_ack_o), .u_dat_o(u_dat_o), .flush_i(flush_i),
      .d_adr_o(d_adr_o), .d_cyc_o(d_cyc_o), .d_stb_o(d_stb_o), .d_we_o(d_we_o),
      .d_sel_o(d_sel_o), .d_dat_o(d_dat_o), .d_ack_i(d_ack_i), .d_dat_i(d_dat_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every acknowledged transfer must match the oldest expected response.
   always @(negedge clk_i) begin
      if (reset_ni && u_ack_o) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_ack", 64'd1, 64'd0);
         end else begin
            logic [16:0] e;
            e = exp_q.pop_front();
            if (e[16]) chk("u_dat_o", {48'd0, u_dat_o}, {48'd0, e[15:0]});
            else       chk("write_ack", {63'd0, u_ack_o}, 64'd1);
         end
      end
   end

   task automatic request(input logic [63:0] adr, input logic we, input logic siz,
                          input logic sgn, input logic [15:0] dat);
      u_adr_i = adr; u_we_i = we; u_siz_i = siz; u_signed_i = sgn; u_dat_i = dat;
      u_cyc_i = 1'b1; u_stb_i = 1'b1;
      @(posedge clk_i); #1;
      u_stb_i = 1'b0;
   endtask

   task automatic downstream(input string name, input int waits, input logic [63:0] rdata);
      for (int i = 0; i < waits; i++) begin
         @(posedge clk_i); #1;
         chk({name, "_cyc_held"}, {63'd0, d_cyc_o}, 64'd1);
      end
      d_ack_i = 1'b1; d_dat_i = rdata;
      @(posedge clk_i); #1;
      d_ack_i = 1'b0; d_dat_i = 64'd0;
      chk({name, "_cyc_drop"}, {63'd0, d_cyc_o}, 64'd0);
   endtask

   task automatic finish_cycle(input string name);
      chk({name, "_ack"}, {63'd0, u_ack_o}, 64'd1);
      @(posedge clk_i); #1;
      u_cyc_i = 1'b0;
      chk({name, "_ack_pulse"}, {63'd0, u_ack_o}, 64'd0);
   endtask

   task automatic rd(input string name, input logic [63:0] adr, input logic siz, input logic sgn,
                     input logic [15:0] exp, input bit hit, input int waits, input logic [63:0] rdata);
      exp_q.push_back({1'b1, exp});
      request(adr, 1'b0, siz, sgn, 16'h0000);
      if (hit) begin
         chk({name, "_hit_nocyc"}, {63'd0, d_cyc_o}, 64'd0);
      end else begin
         chk({name, "_miss_cyc"}, {63'd0, d_cyc_o}, 64'd1);
         chk({name, "_adr"}, d_adr_o, {adr[63:3], 3'b000});
         chk({name, "_sel"}, {56'd0, d_sel_o}, 64'hFF);
         chk({name, "_we"}, {63'd0, d_we_o}, 64'd0);
         downstream(name, waits, rdata);
      end
      finish_cycle(name);
   endtask

   task automatic wr(input string name, input logic [63:0] adr, input logic siz, input logic [15:0] dat,
                     input logic [7:0] sel, input logic [63:0] wdat);
      exp_q.push_back({1'b0, 16'h0000});
      request(adr, 1'b1, siz, 1'b0, dat);
      chk({name, "_cyc"}, {63'd0, d_cyc_o}, 64'd1);
      chk({name, "_stb"}, {63'd0, d_stb_o}, 64'd1);
      chk({name, "_we"}, {63'd0, d_we_o}, 64'd1);
      chk({name, "_adr"}, d_adr_o, {adr[63:3], 3'b000});
      chk({name, "_sel"}, {56'd0, d_sel_o}, {56'd0, sel});
      chk({name, "_dat"}, d_dat_o, wdat);
      downstream(name, 1, 64'd0);
      finish_cycle(name);
   endtask

   initial begin
      reset_ni = 1'b0; u_adr_i = '0; u_cyc_i = 0; u_stb_i = 0; u_we_i = 0; u_siz_i = 0;
      u_signed_i = 0; u_dat_i = 16'h0; flush_i = 0; d_ack_i = 0; d_dat_i = 64'd0;
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_ack", {63'd0, u_ack_o}, 64'd0);
      chk("rst_dat", {48'd0, u_dat_o}, 64'd0);
      chk("rst_cyc", {62'd0, d_cyc_o, d_stb_o}, 64'd0);
      chk("rst_we_sel", {55'd0, d_we_o, d_sel_o}, 64'd0);
      reset_ni = 1'b1;
      @(posedge clk_i); #1;

      rd("fill", 64'h1000, 1'b1, 1'b0, 16'h7788, 1'b0, 0, D0);

      request(64'h2000, 1'b0, 1'b1, 1'b0, 16'h0);
      chk("rst_mid_cyc_before", {63'd0, d_cyc_o}, 64'd1);
      @(posedge clk_i); #1;
      reset_ni = 1'b0;
      #1;
      chk("rst_mid_cyc", {63'd0, d_cyc_o}, 64'd0);
      chk("rst_mid_ack", {63'd0, u_ack_o}, 64'd0);
      u_cyc_i = 1'b0;
      @(posedge clk_i); #1;
      reset_ni = 1'b1;
      @(posedge clk_i); #1;

      rd("after_rst", 64'h1000, 1'b1, 1'b0, 16'h7788, 1'b0, 1, D0);
      rd("hw_1006", 64'h1006, 1'b1, 1'b0, 16'h1122, 1'b0, 3, D0);
      rd("hw_1000", 64'h1000, 1'b1, 1'b0, 16'h7788, LB, 0, D0);
      rd("hw_1003", 64'h1003, 1'b1, 1'b0, 16'h5566, LB, 0, D0);
      rd("b_signed", 64'h1000, 1'b0, 1'b1, 16'hFF88, LB, 0, D0);
      rd("b_unsigned", 64'h1000, 1'b0, 1'b0, 16'h0088, LB, 0, D0);
      rd("b_1005_s", 64'h1005, 1'b0, 1'b1, 16'h0033, LB, 0, D0);
      rd("b_1002_s", 64'h1002, 1'b0, 1'b1, 16'h0066, LB, 0, D0);

      wr("wb_1003", 64'h1003, 1'b0, 16'h00AB, 8'h08, 64'hABABABABABABABAB);
      rd("merge_1002", 64'h1002, 1'b1, 1'b0, 16'hAB66, LB, 0, D1);
      wr("wh_2006", 64'h2006, 1'b1, 16'h1234, 8'hC0, 64'h1234123412341234);
      wr("wb_2000", 64'h2000, 1'b0, 16'h55C3, 8'h01, 64'hC3C3C3C3C3C3C3C3);

      request(64'h3000, 1'b0, 1'b1, 1'b0, 16'h0);
      u_cyc_i = 1'b0;
      chk("abort_cyc", {63'd0, d_cyc_o}, 64'd1);
      downstream("abort", 3, 64'h00000000DEADBEEF);
      chk("abort_no_ack", {63'd0, u_ack_o}, 64'd0);
      @(posedge clk_i); #1;
      chk("abort_no_ack2", {63'd0, u_ack_o}, 64'd0);

      flush_i = 1'b1;
      @(posedge clk_i); #1;
      flush_i = 1'b0;
      rd("after_flush", 64'h3000, 1'b1, 1'b0, 16'hF00D, 1'b0, 2, 64'h000000000000F00D);
      rd("b_3001_s", 64'h3001, 1'b0, 1'b1, 16'hFFF0, LB, 0, 64'h000000000000F00D);

      repeat (3) @(posedge clk_i);
      #1;
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
